// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);
endpackage

// File: rtl/mem_lat_tracker.sv
// Tracks the single outstanding read: who owns it and how far through the
// fixed memory latency it is. The return cycle doubles as a free slot.
module mem_lat_tracker
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   issue,
    input  owner_e owner,
    output logic   ret_valid,
    output owner_e ret_owner,
    output logic   slot_free
);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_lat;

    assign at_lat    = (cnt_q == LAT_C);
    assign ret_valid = (state_q == ST_BUSY) && at_lat;
    assign ret_owner = ret_valid ? owner_q : OWN_NONE;
    assign slot_free = (state_q == ST_IDLE) || ret_valid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        // A new issue in the return cycle simply reloads the tracker.
        if (issue) begin
            state_d = ST_BUSY;
            owner_d = owner;
            cnt_d   = CNT_W'(1);
        end else if (state_q == ST_BUSY) begin
            if (at_lat) begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one BRAM port between instruction fetch and the load/store unit.
// Define ARB_STARVE_GUARD_EN to let a starved fetch override data priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifReq,
    input  logic [ADDR_W-1:0]   ifAddr,
    output logic                ifGnt,
    output logic                ifRvalid,
    output logic [DATA_W-1:0]   ifRdata,
    input  logic                dReq,
    input  logic                dWe,
    input  logic [ADDR_W-1:0]   dAddr,
    input  logic [DATA_W-1:0]   dWdata,
    input  logic [DATA_W/8-1:0] dBe,
    output logic                dGnt,
    output logic                dRvalid,
    output logic [DATA_W-1:0]   dRdata,
    output logic                memEn,
    output logic                memWe,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [DATA_W-1:0]   memWdata,
    output logic [DATA_W/8-1:0] memBe,
    input  logic [DATA_W-1:0]   memRdata,
    output logic                pcStall,
    output logic                ifidStall,
    output logic                memStall
);
    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX || STARVE_LIM < 1) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT must be 1..%0d and STARVE_LIM >= 1", MEM_LAT_MAX);
    end

    logic   slot_free, ret_valid, issue, fetch_pri;
    logic   if_gnt, d_gnt;
    owner_e ret_owner, issue_owner;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIM + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign fetch_pri = (starve_q == SW'(STARVE_LIM));

    // Counts free slots that fetch wanted but lost; it cannot pass the limit
    // because at the limit the next free slot goes to fetch.
    always_comb begin
        starve_d = starve_q;
        if (!ifReq || if_gnt)  starve_d = '0;
        else if (slot_free)    starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    assign fetch_pri = 1'b0;
`endif

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst && slot_free) begin
            if (ifReq && (!dReq || fetch_pri)) if_gnt = 1'b1;
            else if (dReq)                     d_gnt  = 1'b1;
        end
    end

    always_comb begin
        memAddr  = '0;
        memWdata = '0;
        memBe    = '0;
        if (d_gnt) begin
            memAddr  = dAddr;
            memWdata = dWdata;
            memBe    = dWe ? dBe : '1;
        end else if (if_gnt) begin
            memAddr  = ifAddr;
            memBe    = '1;
        end
    end

    assign ifGnt       = if_gnt;
    assign dGnt        = d_gnt;
    assign memEn       = if_gnt | d_gnt;
    assign memWe       = d_gnt & dWe;
    // Stores finish in the grant cycle, so only reads occupy the tracker.
    assign issue       = if_gnt | (d_gnt & ~dWe);
    assign issue_owner = if_gnt ? OWN_IF : OWN_D;

    mem_lat_tracker #(.MEM_LAT(MEM_LAT)) u_trk (
        .clk      (clk),
        .rst      (rst),
        .issue    (issue),
        .owner    (issue_owner),
        .ret_valid(ret_valid),
        .ret_owner(ret_owner),
        .slot_free(slot_free)
    );

    assign ifRvalid  = !rst && ret_valid && (ret_owner == OWN_IF);
    assign dRvalid   = !rst && ret_valid && (ret_owner == OWN_D);
    assign ifRdata   = ifRvalid ? memRdata : '0;
    assign dRdata    = dRvalid  ? memRdata : '0;

    assign pcStall   = !rst && ifReq && !ifRvalid;
    assign ifidStall = pcStall;
    assign memStall  = !rst && dReq && (dWe ? !d_gnt : !dRvalid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a timestamp-based reference model.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int BW   = DW / 8;
    localparam int LAT  = 2;
    localparam int SLIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifReq, dReq, dWe;
    logic [AW-1:0] ifAddr, dAddr;
    logic [DW-1:0] dWdata, memRdata;
    logic [BW-1:0] dBe;
    logic          ifGnt, ifRvalid, dGnt, dRvalid, memEn, memWe;
    logic          pcStall, ifidStall, memStall;
    logic [DW-1:0] ifRdata, dRdata, memWdata;
    logic [AW-1:0] memAddr;
    logic [BW-1:0] memBe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIM(SLIM)) dut (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRvalid(ifRvalid), .ifRdata(ifRdata),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dBe(dBe),
        .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
        .memRdata(memRdata),
        .pcStall(pcStall), .ifidStall(ifidStall), .memStall(memStall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        tick();
        ifReq = 0; dReq = 0; dWe = 0;
        repeat (n) tick();
    endtask

    // Reference model: one pending read remembered by owner and absolute due cycle.
    int cyc = 0;
    bit m_pend = 0;
    int m_due = 0;
    int m_own = 0;  // 1 = fetch, 2 = data
`ifdef ARB_STARVE_GUARD_EN
    int m_starve = 0;
`endif

    always @(negedge clk) begin
        bit ret, free, pri, eig, edg, eir, edr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [BW-1:0] e_be;
        if (rst) begin
            chk("m_rst_ctl", {ifGnt, dGnt, ifRvalid, dRvalid, memEn, memWe, pcStall, ifidStall, memStall}, 0);
            chk("m_rst_bus", ifRdata | dRdata | memWdata | 64'(memAddr) | 64'(memBe), 0);
            m_pend = 0;
`ifdef ARB_STARVE_GUARD_EN
            m_starve = 0;
`endif
        end else begin
            ret  = m_pend && (m_due == cyc);
            free = !m_pend || ret;
            pri  = 0;
`ifdef ARB_STARVE_GUARD_EN
            pri  = (m_starve >= SLIM);
`endif
            eig  = free && ifReq && (!dReq || pri);
            edg  = free && dReq && !eig;
            eir  = ret && (m_own == 1);
            edr  = ret && (m_own == 2);
            e_addr = edg ? dAddr : (eig ? ifAddr : '0);
            e_wd   = edg ? dWdata : '0;
            e_be   = (edg && dWe) ? dBe : ((edg || eig) ? '1 : '0);
            chk("m_ifGnt", ifGnt, eig);
            chk("m_dGnt", dGnt, edg);
            chk("m_memEn", memEn, eig | edg);
            chk("m_memWe", memWe, edg & dWe);
            chk("m_memAddr", memAddr, e_addr);
            chk("m_memWdata", memWdata, e_wd);
            chk("m_memBe", memBe, e_be);
            chk("m_ifRvalid", ifRvalid, eir);
            chk("m_dRvalid", dRvalid, edr);
            chk("m_ifRdata", ifRdata, eir ? memRdata : '0);
            chk("m_dRdata", dRdata, edr ? memRdata : '0);
            chk("m_pcStall", pcStall, ifReq & !eir);
            chk("m_ifidStall", ifidStall, ifReq & !eir);
            chk("m_memStall", memStall, dReq & (dWe ? !edg : !edr));
            if (ret) m_pend = 0;
            if (eig || (edg && !dWe)) begin
                m_pend = 1;
                m_due  = cyc + LAT;
                m_own  = eig ? 1 : 2;
            end
`ifdef ARB_STARVE_GUARD_EN
            if (!ifReq || eig) m_starve = 0;
            else if (free)     m_starve++;
`endif
        end
        cyc++;
    end

    initial begin
        int first;
        rst = 1; ifReq = 1; dReq = 1; dWe = 0;
        ifAddr = 32'h80; dAddr = 32'h40; dWdata = '0; dBe = '0; memRdata = '0;

        // Reset held 3 cycles with both requests high
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", {ifGnt, dGnt, memEn}, 0);
            chk("rst_stall", {pcStall, memStall}, 0);
        end
        tick(); rst = 0;
        @(negedge clk);
        chk("post_rst_dGnt", dGnt, 1);
        chk("post_rst_ifGnt", ifGnt, 0);
        chk("post_rst_rvalid", {ifRvalid, dRvalid}, 0);
        idle(2 * LAT + 2);

        // Lone fetch, return after LAT=2 cycles
        ifReq = 1; ifAddr = 32'h100;
        @(negedge clk);
        chk("fetch_t0_gnt", {ifGnt, memEn}, 2'b11);
        chk("fetch_t0_addr", memAddr, 32'h100);
        chk("fetch_t0_stall", pcStall, 1);
        tick();
        @(negedge clk);
        chk("fetch_t1_gnt", ifGnt, 0);
        chk("fetch_t1_stall", pcStall, 1);
        tick(); memRdata = 64'h13;
        @(negedge clk);
        chk("fetch_t2_rvalid", ifRvalid, 1);
        chk("fetch_t2_rdata", ifRdata, 64'h13);
        chk("fetch_t2_stall", pcStall, 0);
        idle(2 * LAT + 2);

        // Contention: data load wins, fetch granted in the return cycle
        ifReq = 1; ifAddr = 32'h200; dReq = 1; dWe = 0; dAddr = 32'h2000;
        @(negedge clk);
        chk("cont_t0_gnt", {dGnt, ifGnt}, 2'b10);
        chk("cont_t0_addr", memAddr, 32'h2000);
        chk("cont_t0_stall", {ifidStall, memStall}, 2'b11);
        tick(); dReq = 0;
        for (int t = 1; t < LAT; t++) begin
            @(negedge clk);
            chk("cont_wait_stall", {ifidStall, ifGnt}, 2'b10);
            tick();
        end
        memRdata = 64'hAAAA_0000_1111_2222;
        @(negedge clk);
        chk("cont_d_rvalid", dRvalid, 1);
        chk("cont_d_rdata", dRdata, 64'hAAAA_0000_1111_2222);
        chk("cont_if_gnt", ifGnt, 1);
        chk("cont_if_addr", memAddr, 32'h200);
        tick(); ifReq = 0;
        repeat (LAT - 1) tick();
        memRdata = 64'h5555_6666_7777_8888;
        @(negedge clk);
        chk("cont_if_rvalid", {ifRvalid, dRvalid}, 2'b10);
        chk("cont_if_rdata", ifRdata, 64'h5555_6666_7777_8888);
        idle(2 * LAT + 2);

        // Store completes in the grant cycle
        dReq = 1; dWe = 1; dAddr = 32'h3008; dWdata = 64'hDEADBEEF; dBe = 8'h0F;
        @(negedge clk);
        chk("st_gnt_we", {dGnt, memWe}, 2'b11);
        chk("st_be", memBe, 8'h0F);
        chk("st_wdata", memWdata, 64'hDEADBEEF);
        chk("st_stall_rv", {memStall, dRvalid}, 0);
        tick(); dReq = 0; dWe = 0; ifReq = 1; ifAddr = 32'h300;
        @(negedge clk);
        chk("st_next_idle", {ifGnt, dRvalid}, 2'b10);
        idle(2 * LAT + 2);

        // Reset while a load is outstanding
        dReq = 1; dWe = 0; dAddr = 32'h4000;
        @(negedge clk);
        chk("rmid_gnt", dGnt, 1);
        tick(); dReq = 0; rst = 1;
        tick(); rst = 0; ifReq = 1; ifAddr = 32'h440;
        @(negedge clk);
        chk("rmid_idle_gnt", ifGnt, 1);
        tick(); ifReq = 0;
        first = 0;
        repeat (2 * LAT + 2) begin
            @(negedge clk);
            if (dRvalid) first++;
            tick();
        end
        chk("rmid_no_drvalid", first, 0);

        // Continuous data loads against a waiting fetch
        ifReq = 1; ifAddr = 32'h500; dReq = 1; dWe = 0; dAddr = 32'h600;
        first = -1;
        for (int t = 0; t < 6 * LAT + 2; t++) begin
            @(negedge clk);
            if (ifGnt && first < 0) first = t;
            tick();
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_first_ifgnt", first, 4 * LAT);
`else
        chk("starve_first_ifgnt", first, -1);
`endif
        idle(2 * LAT + 2);

        // Randomized traffic, occasional reset
        repeat (1500) begin
            tick();
            rst      = ($urandom_range(0, 59) == 0);
            ifReq    = ($urandom_range(0, 2) != 0);
            dReq     = $urandom_range(0, 1) == 1;
            dWe      = ($urandom_range(0, 2) == 0);
            ifAddr   = $urandom;
            dAddr    = $urandom;
            dWdata   = {$urandom, $urandom};
            dBe      = 8'($urandom);
            memRdata = {$urandom, $urandom};
        end
        tick(); rst = 0;
        idle(4);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory (BRAM) between the IF-stage instruction fetch and the MEM-stage load/store unit of the RV64 pipeline.
- Grants one request per slot and tracks the outstanding read over a fixed memory latency.
- Returns read data to the correct requester.
- Drives pcStall/ifidStall for the front end and memStall for the back end.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 64, memory word width; DATA_W/8 byte enables.
- MEM_LAT, 1, read latency in cycles from memEn to valid memRdata; legal range 1..4, otherwise elaboration error.
- STARVE_LIM, 4, consecutive denied fetch cycles before the starvation guard fires (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ifReq  in  1  fetch read request.
- ifAddr  in  ADDR_W  fetch address.
- ifGnt  out  1  fetch request accepted this cycle.
- ifRvalid  out  1  fetch data valid, 1-cycle pulse.
- ifRdata  out  DATA_W  fetch data.
- dReq  in  1  data request.
- dWe  in  1  1=store, 0=load.
- dAddr  in  ADDR_W  data address.
- dWdata  in  DATA_W  store data.
- dBe  in  DATA_W/8  store byte enables.
- dGnt  out  1  data request accepted.
- dRvalid  out  1  load data valid, 1-cycle pulse.
- dRdata  out  DATA_W  load data.
- memEn  out  1  memory access strobe.
- memWe  out  1  memory write.
- memAddr  out  ADDR_W  memory address.
- memWdata  out  DATA_W  write data.
- memBe  out  DATA_W/8  byte enables.
- memRdata  in  DATA_W  memory read data, valid MEM_LAT cycles after memEn with memWe=0.
- pcStall  out  1  hold PC.
- ifidStall  out  1  hold IF/ID register.
- memStall  out  1  hold EXE/MEM and earlier stages.

Behaviour:
- Reset is synchronous and active-high on clk.
  - State→IDLE, owner→NONE, latency counter→0, starvation counter→0.
  - While rst=1, every output is 0, including the combinational outputs.
- FSM states:
  - IDLE: no read outstanding.
  - BUSY: read outstanding; counter counts 1..MEM_LAT.
- Slot is free when state=IDLE, or state=BUSY and counter=MEM_LAT (the return cycle).
- Grant in a free slot:
  - Data has priority over fetch: dGnt=dReq; ifGnt=ifReq & ~dReq.
  - Grants are combinational, at most one per cycle.
  - memEn=grant; memWe=dWe&dGnt; memBe=dBe for a store, all-ones for a read, 0 when no access.
  - memAddr/memWdata are taken from the granted requester; they are 0 when no grant.
- Store grant: completes in the grant cycle, with no return pulse. If no read was also returning, next state is IDLE.
- Read grant: next state BUSY, owner latched (IF or D), counter=1.
- Return: in the cycle counter=MEM_LAT, the owner's Rvalid=1 and its Rdata=memRdata. The other Rdata is 0.
- Back-to-back: a new grant in the return cycle is legal and reloads owner/counter=1. Sustained throughput is 1 read every MEM_LAT cycles; for MEM_LAT=1, 1 per cycle.
- Requester rules:
  - Hold req/addr/data stable until Gnt.
  - May drop req after Gnt.
  - Must not reissue before its Rvalid.
  - The arbiter does not check these rules.
- Stalls (combinational):
  - pcStall = ifidStall = ifReq & ~ifRvalid.
  - memStall = dReq & (dWe ? ~dGnt : ~dRvalid).
- Reset during BUSY: the outstanding read is abandoned, and no Rvalid is issued after reset deasserts.
- Simultaneous ifReq and dReq in a busy slot: both wait, and both stall signals are asserted.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A starvation counter increments each free-slot cycle in which ifReq=1 and ifGnt=0. It resets to 0 on ifGnt or when ifReq=0.
  - When the counter equals STARVE_LIM, fetch wins the next free slot over dReq, and the counter clears.
- Undefined: strict data-over-fetch priority, and no counter flops exist.

Decomposition:
- Shared package (mem_arb_pkg):
  - Owner enum: NONE=2'd0, IF=2'd1, D=2'd2.
  - State enum: IDLE, BUSY.
  - MEM_LAT_MAX=4.
  - Counter width constant $clog2(MEM_LAT_MAX+1).
- One natural sub-module: mem_lat_tracker.
  - Holds the owner tag and latency counter.
  - Inputs: issue and owner.
  - Outputs: retValid, retOwner, slotFree.
- Top level holds grant priority, muxing, stalls and the optional guard.

Test Plan:
- Reset: assert rst for 3 cycles with ifReq=dReq=1 → all outputs 0. First free-slot grant comes in the cycle after rst deasserts; no stale Rvalid.
- Lone fetch, MEM_LAT=2: ifReq, ifAddr=0x100 → ifGnt at t0, memEn=1, memAddr=0x100; ifRvalid at t2 with memRdata=0x00000013; pcStall=1 at t0–t1 and 0 at t2.
- Contention: ifReq and dReq load 0x2000 both at t0, MEM_LAT=1 → dGnt at t0, dRvalid at t1. ifGnt at t1 (back-to-back), ifRvalid at t2; ifidStall high t0–t1.
- Store: dReq, dWe=1, dAddr=0x3008, dWdata=0xDEADBEEF, dBe=0x0F in IDLE → dGnt, memWe=1, memBe=0x0F in the same cycle. memStall=0, no dRvalid, state stays IDLE.
- Reset mid-read: MEM_LAT=3, grant a load, assert rst at counter=2 → no dRvalid ever; FSM is IDLE after reset.
- Guard (ARB_STARVE_GUARD_EN, STARVE_LIM=4, MEM_LAT=1): continuous dReq loads plus ifReq → ifGnt on the 5th free slot despite dReq=1. Without the macro, ifGnt never asserts while dReq stays high.
